// File: rtl/uart_tx_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_arbiter_if
// Description : Bundle of the two requester ports (A, B) and the UART
//               transmitter handshake used by uart_tx_frame_arbiter.
//               Ports (arbiter view, modport slave):
//                 i_Req_x / i_Data_x[31:0] / i_Len_x[2:0]  frame request in
//                 o_Ack_x                                   frame done pulse
//                 o_Grant[1:0] ({B,A}), o_Busy              ownership status
//                 o_Tx_DV, o_Tx_Byte[7:0]                   byte to transmitter
//                 i_Tx_Active, i_Tx_Done                    transmitter status
//               modport master is the mirror image (requesters + transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_frame_arbiter_if;
  logic        i_Req_A;
  logic [31:0] i_Data_A;
  logic [2:0]  i_Len_A;
  logic        o_Ack_A;
  logic        i_Req_B;
  logic [31:0] i_Data_B;
  logic [2:0]  i_Len_B;
  logic        o_Ack_B;
  logic [1:0]  o_Grant;
  logic        o_Busy;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic        i_Tx_Active;
  logic        i_Tx_Done;

  modport slave (
    input  i_Req_A, i_Data_A, i_Len_A,
    input  i_Req_B, i_Data_B, i_Len_B,
    input  i_Tx_Active, i_Tx_Done,
    output o_Ack_A, o_Ack_B, o_Grant, o_Busy, o_Tx_DV, o_Tx_Byte
  );

  modport master (
    output i_Req_A, i_Data_A, i_Len_A,
    output i_Req_B, i_Data_B, i_Len_B,
    output i_Tx_Active, i_Tx_Done,
    input  o_Ack_A, o_Ack_B, o_Grant, o_Busy, o_Tx_DV, o_Tx_Byte
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_arbiter
// Description : Round-robin arbiter sharing one 8N1 UART transmitter between
//               requesters A and B. A granted frame of 1..MAX_BYTES bytes is
//               fed to the transmitter byte 0 first, one o_Tx_DV pulse per
//               byte, and the owner gets a one-cycle ack after the last stop
//               bit has finished.
// Ports       : i_Clock   - system clock, rising edge
//               i_Reset_n - asynchronous active-low reset
//               bus       - uart_tx_frame_arbiter_if.slave (requests, acks,
//                           grant/busy status, transmitter handshake)
// Parameters  : MAX_BYTES - longest frame; longer requests are clamped
//               GAP_CLKS  - idle clocks between bytes of one frame (0..255)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame_arbiter #(
  parameter int MAX_BYTES = 4,
  parameter int GAP_CLKS  = 0
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  uart_tx_frame_arbiter_if.slave        bus
);

  localparam logic [2:0] c_MAX_LEN  = 3'(MAX_BYTES);
  localparam logic [7:0] c_GAP_LAST = 8'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam bit         c_HAS_GAP  = (GAP_CLKS > 0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_GAP        = 3'd4,
    S_ACK        = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_b_q, last_b_d;   // 1: B was granted last, so A wins a tie
  logic [31:0] data_q, data_d;
  logic [2:0]  len_q, len_d;         // already clamped to MAX_BYTES
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  logic        done_q;
  logic        tx_dv_q, tx_dv_d;
  logic [7:0]  tx_byte_q, tx_byte_d;

  logic        pick_b;
  logic [2:0]  req_len;
  logic [31:0] req_data;
  logic [2:0]  idx_inc;
  logic        done_rise;

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > c_MAX_LEN) ? c_MAX_LEN : len;
  endfunction

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      last_b_q  <= 1'b1;
      data_q    <= 32'd0;
      len_q     <= 3'd0;
      idx_q     <= 3'd0;
      gap_q     <= 8'd0;
      done_q    <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_b_q  <= last_b_d;
      data_q    <= data_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      done_q    <= bus.i_Tx_Done;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_b_d  = last_b_q;
    data_d    = data_q;
    len_d     = len_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;

    // B wins when it is alone, or when both ask and A was served last.
    pick_b    = bus.i_Req_B & (~bus.i_Req_A | ~last_b_q);
    req_len   = pick_b ? clamp_len(bus.i_Len_B) : clamp_len(bus.i_Len_A);
    req_data  = pick_b ? bus.i_Data_B : bus.i_Data_A;
    idx_inc   = idx_q + 3'd1;
    // The transmitter's done pulse lasts two cycles; count only its leading edge.
    done_rise = bus.i_Tx_Done & ~done_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_Req_A | bus.i_Req_B) begin
          grant_d  = pick_b ? 2'b10 : 2'b01;
          last_b_d = pick_b;
          data_d   = req_data;
          len_d    = req_len;
          idx_d    = 3'd0;
          state_d  = (req_len == 3'd0) ? S_ACK : S_LOAD;
        end
      end
      S_LOAD: begin
        // Checking both active and done keeps us out of the transmitter's
        // cleanup cycle, and covers a byte still running after a reset.
        if (!bus.i_Tx_Active && !bus.i_Tx_Done) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = data_q[{idx_q[1:0], 3'b000} +: 8];
          state_d   = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (bus.i_Tx_Active) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (done_rise) begin
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            state_d = S_ACK;
          end else if (c_HAS_GAP) begin
            gap_d   = 8'd0;
            state_d = S_GAP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_q == c_GAP_LAST) begin
          state_d = S_LOAD;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_ACK: begin
        grant_d = 2'b00;
        idx_d   = 3'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_Grant   = grant_q;
  assign bus.o_Busy    = (state_q != S_IDLE);
  assign bus.o_Ack_A   = (state_q == S_ACK) & grant_q[0];
  assign bus.o_Ack_B   = (state_q == S_ACK) & grant_q[1];
  assign bus.o_Tx_DV   = tx_dv_q;
  assign bus.o_Tx_Byte = tx_byte_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame_arbiter
// Description : Self-checking bench. Two arbiters run side by side, instance 0
//               with GAP_CLKS=0 and instance 1 with GAP_CLKS=10, each driving
//               a behavioural 8N1 transmitter (CLKS_PER_BIT=4). A monitor
//               predicts round-robin grants and the byte stream of each frame
//               from the frames the bench submitted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_arbiter;

  localparam int CLKS_PER_BIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req_a = '0, req_b = '0;
  logic [1:0][31:0] data_a = '0, data_b = '0;
  logic [1:0][2:0]  len_a = '0, len_b = '0;
  logic [1:0]       ack_a, ack_b, busy, tx_dv;
  logic [1:0][1:0]  grant;
  logic [1:0][7:0]  tx_byte;
  logic [1:0]       tx_active = '0, tx_done = '0;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      uart_tx_frame_arbiter_if bus ();
      assign bus.i_Req_A     = req_a[g];
      assign bus.i_Data_A    = data_a[g];
      assign bus.i_Len_A     = len_a[g];
      assign bus.i_Req_B     = req_b[g];
      assign bus.i_Data_B    = data_b[g];
      assign bus.i_Len_B     = len_b[g];
      assign bus.i_Tx_Active = tx_active[g];
      assign bus.i_Tx_Done   = tx_done[g];
      assign ack_a[g]        = bus.o_Ack_A;
      assign ack_b[g]        = bus.o_Ack_B;
      assign grant[g]        = bus.o_Grant;
      assign busy[g]         = bus.o_Busy;
      assign tx_dv[g]        = bus.o_Tx_DV;
      assign tx_byte[g]      = bus.o_Tx_Byte;

      uart_tx_frame_arbiter #(
        .MAX_BYTES (4),
        .GAP_CLKS  ((g == 0) ? 0 : 10)
      ) u_dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
      );
    end
  endgenerate

  // Behavioural transmitter: 10 bit times busy, then done for two cycles
  // (stop-bit end plus cleanup). It has no reset, like the real one.
  int m_st [2]  = '{0, 0};
  int m_cnt [2] = '{0, 0};
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      case (m_st[k])
        0: begin
          tx_done[k] <= 1'b0;
          if (tx_dv[k]) begin
            tx_active[k] <= 1'b1;
            m_cnt[k]     <= 0;
            m_st[k]      <= 1;
          end
        end
        1: begin
          if (m_cnt[k] == 10 * CLKS_PER_BIT - 1) begin
            tx_active[k] <= 1'b0;
            tx_done[k]   <= 1'b1;
            m_st[k]      <= 2;
          end else begin
            m_cnt[k] <= m_cnt[k] + 1;
          end
        end
        2: begin
          tx_done[k] <= 1'b1;
          m_st[k]    <= 0;
        end
        default: m_st[k] <= 0;
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frames as submitted by the requesters: [instance][0=A,1=B]
  logic [31:0] fr_data [2][2];
  int          fr_len  [2][2];

  // Reference model state
  logic [1:0]  mon_owner [2];
  int          mon_last_b [2];
  logic [31:0] mon_data [2];
  int          mon_len [2];
  int          got_cnt [2];
  int          dv_total [2];
  int          acka_total [2];
  int          done_rise_cyc [2];
  logic [1:0]  prev_grant [2];
  logic        prev_ra [2], prev_rb [2], prev_dv [2], prev_done [2];
  int          glog [2][64];
  int          glog_n [2];

  task automatic mon_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mon_owner[k]  = 2'b00;
        mon_last_b[k] = 1;
        got_cnt[k]    = 0;
      end else begin
        if (grant[k] != 2'b00 && prev_grant[k] == 2'b00) begin
          logic [1:0] exp_g;
          int w;
          if (prev_ra[k] && prev_rb[k]) exp_g = (mon_last_b[k] != 0) ? 2'b01 : 2'b10;
          else if (prev_ra[k])          exp_g = 2'b01;
          else if (prev_rb[k])          exp_g = 2'b10;
          else                          exp_g = 2'b00;
          check("rr_grant", 32'(grant[k]), 32'(exp_g));
          w             = grant[k][1] ? 1 : 0;
          mon_owner[k]  = grant[k];
          mon_last_b[k] = w;
          mon_data[k]   = fr_data[k][w];
          mon_len[k]    = (fr_len[k][w] > 4) ? 4 : fr_len[k][w];
          got_cnt[k]    = 0;
          if (glog_n[k] < 64) glog[k][glog_n[k]] = w;
          glog_n[k]++;
        end
        if (tx_dv[k]) begin
          logic [31:0] sh;
          check("dv_tx_idle", 32'({tx_active[k], tx_done[k]}), 32'd0);
          check("dv_width", 32'(prev_dv[k]), 32'd0);
          check("grant_hold", 32'(grant[k]), 32'(mon_owner[k]));
          if (k == 1 && got_cnt[k] > 0)
            check("gap_min", ((cyc - done_rise_cyc[k]) >= 11) ? 32'd1 : 32'd0, 32'd1);
          if (got_cnt[k] < mon_len[k]) begin
            sh = mon_data[k] >> (8 * got_cnt[k]);
            check("tx_byte", 32'(tx_byte[k]), 32'(sh[7:0]));
          end else begin
            check("dv_count", 32'(got_cnt[k] + 1), 32'(mon_len[k]));
          end
          got_cnt[k]++;
          dv_total[k]++;
        end
        if (ack_a[k] || ack_b[k]) begin
          check("ack_owner", 32'({ack_b[k], ack_a[k]}), 32'(mon_owner[k]));
          check("frame_bytes", 32'(got_cnt[k]), 32'(mon_len[k]));
          check("busy_at_ack", 32'(busy[k]), 32'd1);
          if (ack_a[k]) acka_total[k]++;
          mon_owner[k] = 2'b00;
        end
      end
      if (tx_done[k] && !prev_done[k]) done_rise_cyc[k] = cyc;
      prev_grant[k] = grant[k];
      prev_ra[k]    = req_a[k];
      prev_rb[k]    = req_b[k];
      prev_dv[k]    = tx_dv[k];
      prev_done[k]  = tx_done[k];
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mon_owner[k] = 2'b00; mon_last_b[k] = 1; mon_data[k] = '0; mon_len[k] = 0;
      got_cnt[k] = 0; dv_total[k] = 0; acka_total[k] = 0; done_rise_cyc[k] = 0;
      prev_grant[k] = 2'b00; prev_ra[k] = 1'b0; prev_rb[k] = 1'b0;
      prev_dv[k] = 1'b0; prev_done[k] = 1'b0; glog_n[k] = 0;
      for (int j = 0; j < 2; j++) begin fr_data[k][j] = '0; fr_len[k][j] = 0; end
    end
    forever begin
      @(negedge clk);
      mon_step();
    end
  end

  task automatic start_req(input int k, input int who, input logic [31:0] d, input logic [2:0] l);
    fr_data[k][who] = d;
    fr_len[k][who]  = int'(l);
    if (who == 0) begin data_a[k] = d; len_a[k] = l; req_a[k] = 1'b1; end
    else          begin data_b[k] = d; len_b[k] = l; req_b[k] = 1'b1; end
  endtask

  // Waits for the ack, scrambling the request inputs once granted, then
  // drops Req at the start of the following cycle.
  task automatic wait_ack(input int k, input int who, output int ncyc);
    bit scrambled = 1'b0;
    bit got = 1'b0;
    ncyc = 0;
    while (!got && ncyc < 6000) begin
      @(negedge clk);
      ncyc++;
      if (grant[k][who] && !scrambled) begin
        scrambled = 1'b1;
        if (who == 0) begin data_a[k] = $urandom; len_a[k] = 3'($urandom_range(0, 7)); end
        else          begin data_b[k] = $urandom; len_b[k] = 3'($urandom_range(0, 7)); end
      end
      got = (who == 0) ? ack_a[k] : ack_b[k];
    end
    check("ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (who == 0) req_a[k] = 1'b0; else req_b[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (!(busy[k] == 1'b0 && tx_active[k] == 1'b0 && tx_done[k] == 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rand_frames(input int k, input int who, input int nfr);
    int nc;
    for (int i = 0; i < nfr; i++) begin
      int dly = $urandom_range(0, 15);
      for (int j = 0; j < dly; j++) begin @(posedge clk); #1; end
      start_req(k, who, $urandom, 3'($urandom_range(0, 7)));
      wait_ack(k, who, nc);
    end
  endtask

  initial begin
    int nc, base, lat, acka_before, n;
    rst_n = 1'b0;

    // Contention straight out of reset
    start_req(0, 0, 32'hAAAA_AAAA, 3'd2);
    start_req(0, 1, 32'hBBBB_BBBB, 3'd2);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_grant", 32'(grant[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_dv_ack", 32'({tx_dv[k], ack_b[k], ack_a[k]}), 32'd0);
    end
    rst_n = 1'b1;
    fork
      begin
        wait_ack(0, 0, nc);
        start_req(0, 0, 32'h0000_CCCC, 3'd2);
        wait_ack(0, 0, nc);
      end
      begin
        wait_ack(0, 1, nc);
      end
    join
    check("order_first_A", 32'(glog[0][0]), 32'd0);
    check("order_then_B", 32'(glog[0][1]), 32'd1);
    check("order_then_A", 32'(glog[0][2]), 32'd0);

    // Single 4-byte A frame, first DV two clocks after the request
    wait_idle(0);
    base = dv_total[0];
    start_req(0, 0, 32'h4433_2211, 3'd4);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (tx_dv[0]) begin lat = i; break; end
    end
    check("dv_latency", 32'(lat), 32'd2);
    wait_ack(0, 0, nc);
    check("single_dv_count", 32'(dv_total[0] - base), 32'd4);

    // Length 0: quick ack, no byte
    wait_idle(0);
    base = dv_total[0];
    start_req(0, 1, 32'h1234_5678, 3'd0);
    wait_ack(0, 1, nc);
    check("len0_ack_cycles", (nc <= 2) ? 32'd1 : 32'd0, 32'd1);
    check("len0_no_dv", 32'(dv_total[0] - base), 32'd0);

    // Length 7 clamps to 4
    wait_idle(0);
    base = dv_total[0];
    start_req(0, 1, $urandom, 3'd7);
    wait_ack(0, 1, nc);
    check("len7_dv_count", 32'(dv_total[0] - base), 32'd4);

    // Gap instance, 3 bytes
    wait_idle(1);
    base = dv_total[1];
    start_req(1, 0, 32'h00C3_B2A1, 3'd3);
    wait_ack(1, 0, nc);
    check("gap_dv_count", 32'(dv_total[1] - base), 32'd3);

    // Randomised traffic on both instances
    fork
      rand_frames(0, 0, 6);
      rand_frames(0, 1, 6);
      rand_frames(1, 0, 5);
      rand_frames(1, 1, 5);
    join

    // Reset in the middle of byte 2 of a 4-byte A frame
    wait_idle(0);
    wait_idle(1);
    base = dv_total[0];
    start_req(0, 0, 32'hDEAD_BEEF, 3'd4);
    n = 0;
    while (dv_total[0] < base + 2 && n < 2000) begin @(negedge clk); n++; end
    check("rst_reach_byte2", (dv_total[0] >= base + 2) ? 32'd1 : 32'd0, 32'd1);
    repeat (12) @(negedge clk);
    acka_before = acka_total[0];
    #1;
    req_a[0] = 1'b0;
    start_req(0, 1, 32'h0000_5A96, 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_grant", 32'(grant[0]), 32'd0);
    check("rst_async_busy", 32'(busy[0]), 32'd0);
    check("rst_async_dv_ack", 32'({tx_dv[0], ack_b[0], ack_a[0]}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ack(0, 1, nc);
    check("rst_no_ackA", 32'(acka_total[0]), 32'(acka_before));

    wait_idle(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame_arbiter.md
Name: uart_tx_frame_arbiter

Overview:
- Shares one 8N1 UART transmitter (serial TX, CLKS_PER_BIT timing, i_Tx_DV/i_Tx_Byte in, o_Tx_Active/o_Tx_Done out) between two requesters A and B.
- Each requester submits a frame of 1-4 bytes in a 32-bit word.
- The block arbitrates round-robin and sequences the frame byte by byte into the transmitter.
- It pulses an acknowledge to the owner once the last stop bit has finished.

Parameters:
- MAX_BYTES, 4: maximum frame length; requested lengths above this are clamped to it.
- GAP_CLKS, 0: idle clocks inserted between consecutive bytes of one frame, range 0-255.

Ports:
- i_Clock  in  1  system clock, rising edge.
- i_Reset_n  in  1  reset, asynchronous and active-low.
- i_Req_A  in  1  A frame request, level; held until o_Ack_A.
- i_Data_A  in  32  A frame data; byte 0 = [7:0] is sent first.
- i_Len_A  in  3  A frame length in bytes.
- o_Ack_A  out  1  one-cycle pulse: A frame fully transmitted.
- i_Req_B, i_Data_B, i_Len_B, o_Ack_B: same as the A ports, for requester B.
- o_Grant  out  2  one-hot current owner ({B,A}); 00 when idle.
- o_Busy  out  1  high from grant until the ack cycle, inclusive.
- o_Tx_DV  out  1  one-cycle pulse to the transmitter's i_Tx_DV.
- o_Tx_Byte  out  8  byte to the transmitter's i_Tx_Byte; valid while o_Tx_DV is high.
- i_Tx_Active  in  1  from the transmitter's o_Tx_Active.
- i_Tx_Done  in  1  from the transmitter's o_Tx_Done (high 2 cycles per byte).

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; byte counter 0; last-granted pointer = B, so A wins first contention.
- States: IDLE, LOAD, WAIT_START, WAIT_DONE, GAP, ACK.
- IDLE:
  - Single request: grant it.
  - Both requests: grant the requester not last-granted; update the pointer.
  - On grant, capture Data and Len into internal registers; set o_Grant and o_Busy; go to LOAD.
  - Later changes on the requester's inputs are ignored until ack.
- Length rules:
  - Len = 0: no byte is sent; go IDLE -> ACK directly.
  - Len > MAX_BYTES: send MAX_BYTES bytes.
- LOAD:
  - Hold until i_Tx_Active=0 and i_Tx_Done=0. This guarantees the transmitter is back in its idle state, including its cleanup cycle.
  - Then assert o_Tx_DV=1 for exactly one cycle, with o_Tx_Byte = captured byte[idx]; go to WAIT_START.
- WAIT_START: wait for i_Tx_Active=1, then go to WAIT_DONE.
- WAIT_DONE:
  - Register i_Tx_Done and detect its rising edge. The 2-cycle done pulse counts as one byte.
  - On the edge, idx+1. If bytes remain: go to GAP when GAP_CLKS > 0, else LOAD. If no bytes remain, go to ACK.
- GAP: count GAP_CLKS cycles, then go to LOAD.
- ACK:
  - Assert o_Ack_x for 1 cycle; o_Grant and o_Busy remain high this cycle.
  - Next cycle: clear grant and busy, set idx=0, return to IDLE.
  - IDLE arbitrates in that same next cycle. A requester must drop Req in response to Ack, or its frame is re-served.
  - Round-robin still favours the other requester, which bounds starvation to one frame.
- Latency: Req high in IDLE -> o_Tx_DV at the earliest 2 clocks later, with the transmitter idle.
- Frame duration: approximately 10*CLKS_PER_BIT per byte plus transmitter overhead plus GAP_CLKS.
- Non-owner requests during a frame: held pending; no effect until IDLE.
- Reset mid-frame:
  - Controller returns to IDLE immediately; no ack is issued; the frame is dropped.
  - The transmitter has no reset and may finish its current byte. LOAD's active/done check prevents issuing a new byte into it.
- o_Tx_DV is never asserted while i_Tx_Active=1 or i_Tx_Done=1.

Test Plan:
- Bench uses CLKS_PER_BIT=4 and GAP_CLKS=0 unless a line says otherwise.
- Single A frame: Req_A=1, Data_A=32'h44_33_22_11, Len_A=4 -> serial line shows bytes 11,22,33,44 in order, each 8N1. Exactly 4 o_Tx_DV pulses; o_Ack_A is one pulse after the 4th stop bit; o_Grant=01 throughout.
- Contention: Req_A and Req_B both 1 out of reset, Len=2 each -> A is served first (AA then BB bytes); B is granted on the cycle after Ack_A. With A re-requesting immediately, B is granted next, then A.
- Length boundaries: Len_B=0 -> Ack_B within 2 cycles, no o_Tx_DV. Len_B=7 -> exactly 4 bytes sent.
- Gap: GAP_CLKS=10, Len=3 -> between byte n's o_Tx_Done rise and byte n+1's o_Tx_DV there are at least 10+1 clocks. No DV pulse occurs while Done=1.
- Reset mid-frame: assert i_Reset_n=0 during byte 2 of 4 -> outputs go to 0 asynchronously; no ack. After release with Req_B pending, the first o_Tx_DV appears only after i_Tx_Active=0 and i_Tx_Done=0.
- Data stability: change Data_A after grant -> the originally captured bytes are transmitted.
